block_mac_2x2: RTL and testbench

- Responder for the 2x2 block hand-off used by the matrix multiplier controller.
- The controller offers one 2x2 A-block and one 2x2 B-block whenever the unit's `in_ready` is high. The unit multiplies the two blocks and adds the product into four internal accumulators.
- When the controller marks a block as the last one of a result square, the unit presents the 2x2 result. It holds the result until the controller acknowledges the write-back.
- Several instances sit in parallel behind the controller, one per "mul ready" slot. Each instance uses a single time-shared multiplier and adder.

---
 rtl/block_mac_2x2_pkg.sv | 16 +
 rtl/block_mac_2x2_mac_lane.sv | 57 +++++
 rtl/block_mac_2x2.sv | 133 +++++++++++++
 tb/tb_block_mac_2x2.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/block_mac_2x2_pkg.sv
// Shared definitions for the 2x2 block multiply-accumulate responder.
//   state_e        : FSM encoding (idle / busy / result)
//   STEP_W         : width of the multiply-accumulate step counter (8 steps)
//   DATA_WIDTH_DEF : default element / accumulator width
package block_mac_2x2_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int STEP_W         = 3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_BUSY   = 2'b01,
    S_RESULT = 2'b10
  } state_e;

endpackage

// File: rtl/block_mac_2x2_mac_lane.sv
// Combinational multiply-add lane shared by all eight steps of a block pair.
// Ports:
//   step_i              : step index 0..7, selects operand pair and accumulator
//   a_*_i, b_*_i        : latched A/B block elements (ul, ur, dl, dr)
//   acc_*_i             : current accumulator values (ul, ur, dl, dr)
//   acc_o               : selected accumulator plus the selected product,
//                         wrapped to W bits
module mac_lane
  import block_mac_2x2_pkg::*;
#(
  parameter int W = DATA_WIDTH_DEF
) (
  input  logic [STEP_W-1:0] step_i,
  input  logic [W-1:0]      a_ul_i,
  input  logic [W-1:0]      a_ur_i,
  input  logic [W-1:0]      a_dl_i,
  input  logic [W-1:0]      a_dr_i,
  input  logic [W-1:0]      b_ul_i,
  input  logic [W-1:0]      b_ur_i,
  input  logic [W-1:0]      b_dl_i,
  input  logic [W-1:0]      b_dr_i,
  input  logic [W-1:0]      acc_ul_i,
  input  logic [W-1:0]      acc_ur_i,
  input  logic [W-1:0]      acc_dl_i,
  input  logic [W-1:0]      acc_dr_i,
  output logic [W-1:0]      acc_o
);

  logic [W-1:0] op_x;
  logic [W-1:0] op_y;
  logic [W-1:0] acc_sel;

  // Step order: c_ul, c_ur, c_dl, c_dr, two products each (step[2:1]
  // picks the accumulator, step[0] picks the inner-product term).
  always_comb begin
    op_x    = '0;
    op_y    = '0;
    acc_sel = '0;
    case (step_i)
      3'd0: begin op_x = a_ul_i; op_y = b_ul_i; acc_sel = acc_ul_i; end
      3'd1: begin op_x = a_ur_i; op_y = b_dl_i; acc_sel = acc_ul_i; end
      3'd2: begin op_x = a_ul_i; op_y = b_ur_i; acc_sel = acc_ur_i; end
      3'd3: begin op_x = a_ur_i; op_y = b_dr_i; acc_sel = acc_ur_i; end
      3'd4: begin op_x = a_dl_i; op_y = b_ul_i; acc_sel = acc_dl_i; end
      3'd5: begin op_x = a_dr_i; op_y = b_dl_i; acc_sel = acc_dl_i; end
      3'd6: begin op_x = a_dl_i; op_y = b_ur_i; acc_sel = acc_dr_i; end
      3'd7: begin op_x = a_dr_i; op_y = b_dr_i; acc_sel = acc_dr_i; end
      default: begin op_x = '0; op_y = '0; acc_sel = '0; end
    endcase
  end

  // The low W bits of a two's complement product do not depend on whether
  // the operands are treated as signed, so a W x W -> W multiply gives the
  // truncated full-width signed product directly.
  assign acc_o = acc_sel + (op_x * op_y);

endmodule

// File: rtl/block_mac_2x2.sv
// 2x2 block multiply-accumulate responder with one time-shared multiplier.
// Ports:
//   clk, reset (async, active-low)
//   in_valid/in_ready      : block pair offer; a pair is taken on a rising
//                            edge where both are high. in_ready is high only
//                            in S_IDLE, and the controller holds its data
//                            until the pair is taken.
//   in_first, in_last      : clear accumulators first / pair ends a result
//   a_*, b_*               : A and B block elements (ul, ur, dl, dr)
//   result_valid/result_ack: result hand-off; result is held while
//                            result_valid is high and released on an edge
//                            where both are high
//   c_*                    : accumulators, meaningful while result_valid
//   state_dbg              : current FSM state for observation
module block_mac_2x2
  import block_mac_2x2_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_first,
  input  logic                  in_last,
  input  logic [DATA_WIDTH-1:0] a_ul,
  input  logic [DATA_WIDTH-1:0] a_ur,
  input  logic [DATA_WIDTH-1:0] a_dl,
  input  logic [DATA_WIDTH-1:0] a_dr,
  input  logic [DATA_WIDTH-1:0] b_ul,
  input  logic [DATA_WIDTH-1:0] b_ur,
  input  logic [DATA_WIDTH-1:0] b_dl,
  input  logic [DATA_WIDTH-1:0] b_dr,
  output logic                  result_valid,
  input  logic                  result_ack,
  output logic [DATA_WIDTH-1:0] c_ul,
  output logic [DATA_WIDTH-1:0] c_ur,
  output logic [DATA_WIDTH-1:0] c_dl,
  output logic [DATA_WIDTH-1:0] c_dr,
  output logic [1:0]            state_dbg
);

  // Element index: 0 = ul, 1 = ur, 2 = dl, 3 = dr.
  state_e                         state_q, state_d;
  logic [STEP_W-1:0]              step_q, step_d;
  logic                           last_q, last_d;
  logic [3:0][DATA_WIDTH-1:0]     a_q, a_d;
  logic [3:0][DATA_WIDTH-1:0]     b_q, b_d;
  logic [3:0][DATA_WIDTH-1:0]     c_q, c_d;
  logic [DATA_WIDTH-1:0]          lane_acc;

  mac_lane #(.W(DATA_WIDTH)) u_lane (
    .step_i   (step_q),
    .a_ul_i   (a_q[0]),
    .a_ur_i   (a_q[1]),
    .a_dl_i   (a_q[2]),
    .a_dr_i   (a_q[3]),
    .b_ul_i   (b_q[0]),
    .b_ur_i   (b_q[1]),
    .b_dl_i   (b_q[2]),
    .b_dr_i   (b_q[3]),
    .acc_ul_i (c_q[0]),
    .acc_ur_i (c_q[1]),
    .acc_dl_i (c_q[2]),
    .acc_dr_i (c_q[3]),
    .acc_o    (lane_acc)
  );

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    last_d  = last_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = {a_dr, a_dl, a_ur, a_ul};
          b_d     = {b_dr, b_dl, b_ur, b_ul};
          last_d  = in_last;
          step_d  = '0;
          state_d = S_BUSY;
          if (in_first) begin
            c_d = '0;
          end
        end
      end
      S_BUSY: begin
        // step[2:1] matches the element index of the accumulator being updated.
        c_d[step_q[2:1]] = lane_acc;
        step_d           = step_q + 3'd1;
        if (step_q == 3'd7) begin
          step_d  = '0;
          state_d = last_q ? S_RESULT : S_IDLE;
        end
      end
      S_RESULT: begin
        if (result_ack) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      last_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      last_q  <= last_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
    end
  end

  assign in_ready     = (state_q == S_IDLE);
  assign result_valid = (state_q == S_RESULT);
  assign c_ul         = c_q[0];
  assign c_ur         = c_q[1];
  assign c_dl         = c_q[2];
  assign c_dr         = c_q[3];
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_block_mac_2x2.sv
// Self-checking bench for block_mac_2x2: table of block pairs with
// hand-computed results, plus directed sequences for held offers,
// mid-computation reset and stray acknowledges.
module tb_block_mac_2x2;
  import block_mac_2x2_pkg::*;

  localparam int W = 32;

  // Element index: 0 = ul, 1 = ur, 2 = dl, 3 = dr.
  typedef struct packed {
    logic [3:0][W-1:0] a;
    logic [3:0][W-1:0] b;
    logic [3:0][W-1:0] c;
    logic              first;
    logic              last;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0, result_ack = 1'b0;
  logic [W-1:0] a_ul = '0, a_ur = '0, a_dl = '0, a_dr = '0;
  logic [W-1:0] b_ul = '0, b_ur = '0, b_dl = '0, b_dr = '0;
  logic         in_ready, result_valid;
  logic [W-1:0] c_ul, c_ur, c_dl, c_dr;
  logic [1:0]   state_dbg;

  block_mac_2x2 #(.DATA_WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_last(in_last),
    .a_ul(a_ul), .a_ur(a_ur), .a_dl(a_dl), .a_dr(a_dr),
    .b_ul(b_ul), .b_ur(b_ur), .b_dl(b_dl), .b_dr(b_dr),
    .result_valid(result_valid), .result_ack(result_ack),
    .c_ul(c_ul), .c_ur(c_ur), .c_dl(c_dl), .c_dr(c_dr),
    .state_dbg(state_dbg)
  );

  // scoreboard
  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  vec_t vecs[6];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] dut_c(input int k);
    case (k)
      0: return c_ul;
      1: return c_ur;
      2: return c_dl;
      default: return c_dr;
    endcase
  endfunction

  function automatic vec_t mk(input logic [W-1:0] a0, a1, a2, a3,
                              input logic [W-1:0] b0, b1, b2, b3,
                              input logic [W-1:0] c0, c1, c2, c3,
                              input logic f, l);
    vec_t v;
    v.a = {a3, a2, a1, a0};
    v.b = {b3, b2, b1, b0};
    v.c = {c3, c2, c1, c0};
    v.first = f;
    v.last = l;
    return v;
  endfunction

  // driver tasks (always entered and left at a falling edge)
  task automatic drive_data(input vec_t v);
    a_ul = v.a[0]; a_ur = v.a[1]; a_dl = v.a[2]; a_dr = v.a[3];
    b_ul = v.b[0]; b_ur = v.b[1]; b_dl = v.b[2]; b_dr = v.b[3];
    in_first = v.first;
    in_last  = v.last;
  endtask

  task automatic drive_random;
    a_ul = $urandom; a_ur = $urandom; a_dl = $urandom; a_dr = $urandom;
    b_ul = $urandom; b_ur = $urandom; b_dl = $urandom; b_dr = $urandom;
    in_first = 1'($urandom_range(0, 1));
    in_last  = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_ready;
    int budget = 0;
    while (!in_ready && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic check_result;
    for (int k = 0; k < 4; k++) begin
      if (exp_q.size() == 0) check("exp_q_empty", 32'd0, 32'd1);
      else check($sformatf("c_%0d", k), dut_c(k), exp_q.pop_front());
    end
  endtask

  // Offers one pair, checks the 8 busy cycles and the state at T+9.
  task automatic send(input vec_t v, input bit ack_in_busy);
    drive_data(v);
    in_valid = 1'b1;
    wait_ready();
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    drive_random();
    if (v.last) for (int k = 0; k < 4; k++) exp_q.push_back(v.c[k]);
    check("busy_state", 32'(state_dbg), 32'(S_BUSY));
    for (int i = 1; i <= 8; i++) begin
      check("busy_in_ready", 32'(in_ready), 32'd0);
      check("busy_result_valid", 32'(result_valid), 32'd0);
      result_ack = ack_in_busy && (i == 3);
      @(negedge clk);
    end
    result_ack = 1'b0;
    check("done_result_valid", 32'(result_valid), 32'(v.last));
    check("done_in_ready", 32'(in_ready), 32'(!v.last));
    if (v.last) check_result();
  endtask

  task automatic take_result;
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    check("ack_result_valid", 32'(result_valid), 32'd0);
    check("ack_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0][W-1:0] snap;

    //         A ul,ur,dl,dr                           B ul,ur,dl,dr                           C ul,ur,dl,dr           first last
    vecs[0] = mk(1, 2, 3, 4,                           5, 6, 7, 8,                             19, 22, 43, 50,         0, 1); // first=0 right after reset
    vecs[1] = mk(1, 2, 3, 4,                           5, 6, 7, 8,                             19, 22, 43, 50,         1, 1);
    vecs[2] = mk(1, 2, 3, 4,                           5, 6, 7, 8,                             0, 0, 0, 0,             1, 0);
    vecs[3] = mk(1, 0, 0, 1,                           1, 0, 0, 1,                             20, 22, 43, 51,         0, 1);
    vecs[4] = mk(32'h7FFFFFFF, 0, 0, 0,                2, 0, 0, 0,                             32'hFFFFFFFE, 0, 0, 0,  1, 1);
    vecs[5] = mk(32'hFFFFFFFF, 2, 32'hFFFFFFFD, 4,     5, 32'hFFFFFFFA, 7, 8,                  9, 22, 13, 50,          1, 1);

    // reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_result_valid", 32'(result_valid), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(S_IDLE));
    for (int k = 0; k < 4; k++) check("rst_c", dut_c(k), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // table-driven pairs
    for (int i = 0; i < 6; i++) begin
      send(vecs[i], 1'b0);
      if (vecs[i].last) take_result();
    end

    // offer held high with changing data through busy and result phases
    drive_data(vecs[1]);
    in_valid = 1'b1;
    wait_ready();
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) exp_q.push_back(vecs[1].c[k]);
    for (int i = 1; i <= 8; i++) begin
      drive_random();
      in_first = 1'b1;
      check("hold_busy_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    check("hold_result_valid", 32'(result_valid), 32'd1);
    check_result();
    snap = {c_dr, c_dl, c_ur, c_ul};
    for (int h = 0; h < 5; h++) begin
      check("hold_valid_stable", 32'(result_valid), 32'd1);
      for (int k = 0; k < 4; k++) check("hold_c_stable", dut_c(k), snap[k]);
      drive_random();
      in_first = 1'b1;
      @(negedge clk);
    end
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    check("post_ack_in_ready", 32'(in_ready), 32'd1);
    check("post_ack_result_valid", 32'(result_valid), 32'd0);
    send(vecs[4], 1'b0);
    take_result();

    // reset during step 4 of a last pair
    drive_data(vecs[1]);
    in_valid = 1'b1;
    wait_ready();
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_result_valid", 32'(result_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_state", 32'(state_dbg), 32'(S_IDLE));
    for (int k = 0; k < 4; k++) check("midrst_c", dut_c(k), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("postrst_no_result", 32'(result_valid), 32'd0);
    end
    send(vecs[1], 1'b0);
    take_result();

    // stray acknowledges in idle and busy
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    check("idle_ack_state", 32'(state_dbg), 32'(S_IDLE));
    check("idle_ack_result_valid", 32'(result_valid), 32'd0);
    check("idle_ack_in_ready", 32'(in_ready), 32'd1);
    send(vecs[2], 1'b1);
    send(vecs[3], 1'b0);
    take_result();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
